// File: rtl/transmitter.sv
// UART transmit stage: serialises one DATA_BITS word per frame as start bit,
// LSB-first data, optional parity, then stop bits. TXD is registered and idles high.
module transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 TXD,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [IW-1:0]        idx, idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 par, par_next;
  logic                 stop_cnt, stop_cnt_next;
  logic                 txd_next, busy_next, done_next;
  logic                 bit_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      par      <= 1'b0;
      stop_cnt <= 1'b0;
      TXD      <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      idx      <= idx_next;
      shift    <= shift_next;
      par      <= par_next;
      stop_cnt <= stop_cnt_next;
      TXD      <= txd_next;
      tx_busy  <= busy_next;
      tx_done  <= done_next;
    end
  end

  // Outputs are computed one cycle ahead so TXD/tx_busy/tx_done come straight from flops.
  always_comb begin
    state_next    = state;
    cnt_next      = '0;
    idx_next      = idx;
    shift_next    = shift;
    par_next      = par;
    stop_cnt_next = stop_cnt;
    txd_next      = TXD;
    busy_next     = tx_busy;
    done_next     = 1'b0;
    bit_end       = (cnt == CNT_LAST);

    if (state != IDLE && !bit_end) cnt_next = cnt + 1'b1;

    unique case (state)
      IDLE: begin
        txd_next  = 1'b1;
        busy_next = 1'b0;
        if (send) begin
          shift_next = data_in;
          par_next   = (^data_in) ^ ODD;
          state_next = START;
          txd_next   = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          idx_next   = '0;
          txd_next   = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift >> 1;
          if (idx == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_next = PARITY;
              txd_next   = par;
            end else begin
              state_next    = STOP;
              txd_next      = 1'b1;
              stop_cnt_next = 1'b0;
            end
          end else begin
            idx_next = idx + 1'b1;
            txd_next = shift[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next    = STOP;
          txd_next      = 1'b1;
          stop_cnt_next = 1'b0;
        end
      end
      STOP: begin
        if (stop_cnt == STOP_LAST && cnt == CNT_DONE) done_next = 1'b1;
        if (bit_end) begin
          if (stop_cnt != STOP_LAST) begin
            stop_cnt_next = 1'b1;
          end else if (send) begin
            // Back-to-back: the final stop edge doubles as the next frame's accept edge.
            shift_next = data_in;
            par_next   = (^data_in) ^ ODD;
            state_next = START;
            txd_next   = 1'b0;
            busy_next  = 1'b1;
          end else begin
            state_next = IDLE;
            txd_next   = 1'b1;
            busy_next  = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_transmitter.sv
// Drives three differently configured transmitters with shared stimulus and
// compares every cycle against a frame-level model of the serial line.
module tb_transmitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       txd[3];
  logic       busy[3];
  logic       done[3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(rst_n), .send(send), .data_in(data),
    .TXD(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(rst_n), .send(send), .data_in(data),
    .TXD(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  transmitter #(.CLKS_PER_BIT(3), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(rst_n), .send(send), .data_in(data),
    .TXD(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  function automatic int cfg_cpb(int i);  return (i == 2) ? 3 : 4; endfunction
  function automatic int cfg_pe(int i);   return (i != 0) ? 1 : 0; endfunction
  function automatic int cfg_odd(int i);  return (i == 2) ? 1 : 0; endfunction
  function automatic int cfg_sb(int i);   return (i == 1) ? 2 : 1; endfunction
  function automatic int flen(int i);
    return (1 + 8 + cfg_pe(i) + cfg_sb(i)) * cfg_cpb(i);
  endfunction

  // Line level at elapsed cycle e of a frame carrying byte d.
  function automatic logic level(int i, logic [7:0] d, int e);
    int b;
    b = e / cfg_cpb(i);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (cfg_pe(i) != 0 && b == 9) return (cfg_odd(i) != 0) ? ~(^d) : ^d;
    return 1'b1;
  endfunction

  bit         act[3];
  int         el[3];
  logic [7:0] byt[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        act[i] <= 1'b0;
        el[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (act[i] && el[i] != flen(i) - 1) begin
          el[i] <= el[i] + 1;
        end else if (send) begin
          act[i] <= 1'b1;
          el[i]  <= 0;
          byt[i] <= data;
        end else begin
          act[i] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("txd%0d", i),  32'(txd[i]),  32'(act[i] ? level(i, byt[i], el[i]) : 1'b1));
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(act[i]));
      check($sformatf("done%0d", i), 32'(done[i]), 32'(act[i] && el[i] == flen(i) - 1));
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_all();
    end
  endtask

  // Independent line decoder on dut0: mid-bit sampling from the start edge.
  task automatic rx_decode(input logic [7:0] want);
    logic [7:0] b;
    int         w;
    b = '0;
    w = 0;
    while (txd[0] !== 1'b0 && w < 20) begin
      step();
      w++;
    end
    check("rx_start_seen", 32'(txd[0] === 1'b0), 32'd1);
    step(2);
    check("rx_start_mid", 32'(txd[0]), 32'd0);
    for (int j = 0; j < 8; j++) begin
      step(4);
      b[j] = txd[0];
    end
    step(4);
    check("rx_stop", 32'(txd[0]), 32'd1);
    check("rx_byte", 32'(b), 32'(want));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset held with send asserted: nothing may start.
    rst_n = 1'b0;
    send  = 1'b1;
    data  = 8'hA5;
    step(5);
    rst_n = 1'b1;
    step();
    send = 1'b0;
    step(60);

    // Parity frame.
    send = 1'b1; data = 8'h07; step(); send = 1'b0;
    step(60);

    // Send during data bit 2 is ignored.
    send = 1'b1; data = 8'h3C; step(); send = 1'b0;
    step(11);
    send = 1'b1; data = 8'hFF; step(); send = 1'b0; data = 8'h00;
    step(60);

    // Held send: contiguous frames, data changed mid-frame.
    send = 1'b1; data = 8'h55;
    step(20);
    data = 8'h0F;
    step(30);
    send = 1'b0;
    step(70);

    // Asynchronous abort during data bit 3, then a clean frame.
    send = 1'b1; data = 8'h5A; step(); send = 1'b0;
    step(17);
    #2 rst_n = 1'b0;
    #1 check("abort_txd", 32'(txd[0]), 32'd1);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check_all();
    step(3);
    rst_n = 1'b1;
    step(2);
    send = 1'b1; data = 8'h81; step(); send = 1'b0; data = 8'h00;
    rx_decode(8'h81);
    step(60);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      send = ($urandom_range(0, 9) == 0);
      data = 8'($urandom);
      step();
    end
    send = 1'b0;
    step(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/transmitter.md
Name: transmitter

Overview:
UART transmit stage sitting directly upstream of the receiver. It serialises a parallel byte into an asynchronous frame: start bit, data LSB first, optional parity, and stop bit(s). The frame is driven on TXD, which connects straight to the receiver's RXD line. It uses a simple send/busy handshake toward the host logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period (>=2)
DATA_BITS, 8, data bits per frame (5..8)
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
send  input  1  request to transmit data_in; sampled on rising clk
data_in  input  DATA_BITS  byte to transmit; captured when send is accepted
TXD  output  1  serial line, idle high; feeds receiver RXD
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset, asynchronous, while reset=0: TXD=1, tx_busy=0, tx_done=0, FSM=IDLE, baud counter=0, bit index=0, shift register=0.
- All outputs are registered. TXD never glitches between clock edges.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TXD=1, tx_busy=0. If send=1 on edge k:
  - latch data_in into the shift register, compute parity;
  - go to START;
  - from edge k onward TXD=0 and tx_busy=1 (latency 1 edge from send).
- Baud counter counts 0..CLKS_PER_BIT-1. Each bit is held exactly CLKS_PER_BIT cycles. State/bit advances when the counter hits CLKS_PER_BIT-1, and the counter then wraps to 0.
- START -> DATA after one bit period.
- DATA:
  - TXD = shift[0], LSB first; shift right after each bit period.
  - Bit index runs 0..DATA_BITS-1.
  - After the last bit: go to PARITY if PARITY_EN, else STOP.
- PARITY: TXD = XOR of captured data (even), or its inverse if PARITY_ODD. Held one bit period.
- STOP: TXD=1 for STOP_BITS bit periods.
  - On the final cycle of the final stop bit: tx_done=1 for exactly one cycle.
  - If send=0 on that edge: go to IDLE, tx_busy falls.
  - If send=1 on that edge: capture the new data_in, go directly to START. tx_busy stays 1, giving back-to-back frames with no idle gap.
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- send while tx_busy=1 (except the final stop cycle) is ignored. Nothing is queued, and there is no effect on the current frame.
- data_in changes after capture do not affect the frame in flight.
- Reset asserted mid-frame: the frame aborts immediately and TXD returns to 1 asynchronously. After release, the block is in IDLE and waits for send.
- Unused upper data bits do not exist: width is exactly DATA_BITS.

Test Plan:
1. Hold reset=0 for 5 cycles with send=1 -> TXD=1, tx_busy=0, tx_done=0 throughout. No frame starts until 1 cycle after reset release.
2. CLKS_PER_BIT=4, pulse send with data_in=8'hA5 -> TXD levels 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_busy high for 40 cycles. tx_done pulses once on cycle 40.
3. PARITY_EN=1, PARITY_ODD=0, data 8'h07 -> parity bit 1, frame 44 cycles. Same with PARITY_ODD=1 -> parity bit 0. STOP_BITS=2 -> stop high for 8 cycles.
4. Start a frame with 8'h3C, pulse send with 8'hFF at data bit 2 -> ignored. Frame is exactly 3C, and TXD stays idle after tx_done.
5. send held high, data_in=8'h55 then changed to 8'h0F during the first frame -> two contiguous frames (55 then 0F) with no idle cycle. tx_busy stays high across the boundary, and tx_done pulses twice.
6. Assert reset during data bit 3 -> TXD=1 and tx_busy=0 immediately. After release, send 8'h81 -> complete, correct frame. Loop TXD into receiver RXD and confirm the receiver decodes 8'h81.
